// File: rtl/bcd_reaction_timer.sv
// bcd_reaction_timer: four-digit cascaded BCD millisecond timer (s.ds cs ms)
// with a built-in 1 ms tick prescaler and active-low seven-segment decode.
// Optional build macro GOBUFFS_SCROLL_EN adds a msg_mode input that swaps the
// displays for a scrolling "GO bUFFS" message ring.
module bcd_reaction_timer #(
  parameter int TICK_DIV   = 50000,
  parameter bit SATURATE   = 1'b1,
  parameter int SCROLL_DIV = 10000000
) (
  input  logic        clk,
  input  logic        clear_,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_data,
`ifdef GOBUFFS_SCROLL_EN
  input  logic        msg_mode,
`endif
  output logic [15:0] count,
  output logic        rco,
  output logic        ovf,
  output logic [7:0]  hex0,
  output logic [7:0]  hex1,
  output logic [7:0]  hex2,
  output logic [7:0]  hex3,
  output logic [7:0]  hex4,
  output logic [7:0]  hex5
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  // Reject parameter values the prescaler and scroll divider cannot honour.
  if (TICK_DIV < 2 || SCROLL_DIV < 1) begin : g_param_check
    $error("bcd_reaction_timer: TICK_DIV must be >= 2 and SCROLL_DIV >= 1");
  end

  logic [PW-1:0] presc;
  logic [16:0]   inc;

  // BCD increment with ripple carry; bit 16 is the carry out of the s digit.
  function automatic logic [16:0] bcd_inc(input logic [15:0] c);
    logic [15:0] r;
    logic        cy;
    r  = c;
    cy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (cy) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          cy          = 1'b0;
        end
      end
    end
    return {cy, r};
  endfunction

  // Non-decimal load digits are stored as zero so count is always valid BCD.
  function automatic logic [15:0] bcd_sanitize(input logic [15:0] d);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = (d[4*i +: 4] > 4'd9) ? 4'd0 : d[4*i +: 4];
    end
    return r;
  endfunction

  // Active-low segment code {dp,g,f,e,d,c,b,a} with dp dark.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  assign inc = bcd_inc(count);

  // Prescaler, BCD counter, overflow pulse and sticky flag.
  always_ff @(posedge clk) begin
    if (!clear_) begin
      count <= 16'h0000;
      presc <= '0;
      rco   <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= bcd_sanitize(load_data);
      presc <= '0;
      rco   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      rco <= 1'b0;
      if (en) begin
        if (presc == PRESC_MAX) begin
          presc <= '0;
          if (inc[16]) begin
            rco   <= 1'b1;
            ovf   <= 1'b1;
            count <= SATURATE ? count : 16'h0000;
          end else begin
            count <= inc[15:0];
          end
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

`ifdef GOBUFFS_SCROLL_EN
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [SW-1:0] SDIV_MAX = SW'(SCROLL_DIV - 1);

  logic [3:0]    idx;
  logic [SW-1:0] sdiv;

  // Message ring "G O _ b U F F S _ _".
  function automatic logic [7:0] glyph(input logic [3:0] i);
    case (i)
      4'd0:    glyph = 8'hC2;
      4'd1:    glyph = 8'hC0;
      4'd3:    glyph = 8'h83;
      4'd4:    glyph = 8'hC1;
      4'd5:    glyph = 8'h8E;
      4'd6:    glyph = 8'h8E;
      4'd7:    glyph = 8'h92;
      default: glyph = 8'hFF;
    endcase
  endfunction

  // Ring position idx+k modulo 10 (idx <= 9, k <= 5).
  function automatic logic [3:0] ring(input logic [3:0] i, input logic [3:0] k);
    logic [4:0] s;
    s = {1'b0, i} + {1'b0, k};
    if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

  // Scroll position advances every SCROLL_DIV cycles while the message is shown.
  always_ff @(posedge clk) begin
    if (!clear_ || !msg_mode) begin
      idx  <= 4'd0;
      sdiv <= '0;
    end else if (sdiv == SDIV_MAX) begin
      sdiv <= '0;
      idx  <= (idx == 4'd9) ? 4'd0 : idx + 4'd1;
    end else begin
      sdiv <= sdiv + 1'b1;
    end
  end
`endif

  // Display select: time (cs, ds, s with dp lit) or the scrolling message.
  always_comb begin
    hex0 = seg7(count[7:4]);
    hex1 = seg7(count[11:8]);
    hex2 = seg7(count[15:12]) & 8'h7F;
    hex3 = 8'hFF;
    hex4 = 8'hFF;
    hex5 = 8'hFF;
`ifdef GOBUFFS_SCROLL_EN
    if (msg_mode) begin
      hex5 = glyph(idx);
      hex4 = glyph(ring(idx, 4'd1));
      hex3 = glyph(ring(idx, 4'd2));
      hex2 = glyph(ring(idx, 4'd3));
      hex1 = glyph(ring(idx, 4'd4));
      hex0 = glyph(ring(idx, 4'd5));
    end
`endif
  end

endmodule

// File: tb/tb_bcd_reaction_timer.sv
// tb_bcd_reaction_timer: directed scenarios followed by randomized traffic on a
// saturating and a wrapping instance, both compared against a behavioural
// integer-millisecond reference model. Build with GOBUFFS_SCROLL_EN to cover
// the message display as well.
module tb_bcd_reaction_timer;

  localparam int TICK_DIV   = 2;
  localparam int SCROLL_DIV = 3;

  logic        clk;
  logic        clear_;
  logic        en;
  logic        load;
  logic [15:0] load_data;
  logic [15:0] count_a, count_b;
  logic        rco_a, rco_b, ovf_a, ovf_b;
  logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
  logic [7:0]  bh0, bh1, bh2, bh3, bh4, bh5;
`ifdef GOBUFFS_SCROLL_EN
  logic        msg_mode;
`endif

  int n_err = 0;
  int n_chk = 0;

  // Reference model state: elapsed milliseconds per instance, prescaler, flags.
  int val [2];
  bit mrco [2];
  bit movf [2];
  int presc;
  int midx, mdiv;

  bcd_reaction_timer #(.TICK_DIV(TICK_DIV), .SATURATE(1'b1), .SCROLL_DIV(SCROLL_DIV)) u_sat (
    .clk(clk), .clear_(clear_), .en(en), .load(load), .load_data(load_data),
`ifdef GOBUFFS_SCROLL_EN
    .msg_mode(msg_mode),
`endif
    .count(count_a), .rco(rco_a), .ovf(ovf_a),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
  );

  bcd_reaction_timer #(.TICK_DIV(TICK_DIV), .SATURATE(1'b0), .SCROLL_DIV(SCROLL_DIV)) u_wrap (
    .clk(clk), .clear_(clear_), .en(en), .load(load), .load_data(load_data),
`ifdef GOBUFFS_SCROLL_EN
    .msg_mode(msg_mode),
`endif
    .count(count_b), .rco(rco_b), .ovf(ovf_b),
    .hex0(bh0), .hex1(bh1), .hex2(bh2), .hex3(bh3), .hex4(bh4), .hex5(bh5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic int from_bcd(input logic [15:0] d);
    int s = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      if (d[4*i +: 4] <= 4'd9) s += int'(d[4*i +: 4]) * w;
      w *= 10;
    end
    return s;
  endfunction

  function automatic logic [7:0] digit_code(input int d);
    logic [7:0] tbl [10];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    return tbl[d];
  endfunction

  function automatic logic [7:0] msg_code(input int i);
    logic [7:0] tbl [10];
    tbl = '{8'hC2, 8'hC0, 8'hFF, 8'h83, 8'hC1, 8'h8E, 8'h8E, 8'h92, 8'hFF, 8'hFF};
    return tbl[i % 10];
  endfunction

  // Advance the reference model by one clock edge using the applied inputs.
  task automatic model_step(input bit c, input bit e, input bit l, input logic [15:0] d, input bit mm);
    if (!c) begin
      presc = 0;
      for (int i = 0; i < 2; i++) begin val[i] = 0; mrco[i] = 0; movf[i] = 0; end
    end else if (l) begin
      presc = 0;
      for (int i = 0; i < 2; i++) begin val[i] = from_bcd(d); mrco[i] = 0; movf[i] = 0; end
    end else begin
      for (int i = 0; i < 2; i++) mrco[i] = 0;
      if (e) begin
        if (presc == TICK_DIV - 1) begin
          presc = 0;
          for (int i = 0; i < 2; i++) begin
            if (val[i] == 9999) begin
              mrco[i] = 1;
              movf[i] = 1;
              val[i]  = (i == 0) ? 9999 : 0;
            end else begin
              val[i]++;
            end
          end
        end else begin
          presc++;
        end
      end
    end
    if (!c || !mm) begin
      midx = 0;
      mdiv = 0;
    end else if (mdiv == SCROLL_DIV - 1) begin
      mdiv = 0;
      midx = (midx + 1) % 10;
    end else begin
      mdiv++;
    end
  endtask

  // Apply inputs, clock once, then compare every output with the model.
  task automatic cyc(input bit c, input bit e, input bit l, input logic [15:0] d);
    logic [7:0] eh [6];
    bit mm;
    mm = 1'b0;
`ifdef GOBUFFS_SCROLL_EN
    mm = msg_mode;
`endif
    clear_    = c;
    en        = e;
    load      = l;
    load_data = d;
    @(posedge clk);
    model_step(c, e, l, d, mm);
    #1;
    if (mm) begin
      for (int k = 0; k < 6; k++) eh[k] = msg_code(midx + 5 - k);
    end else begin
      eh[0] = digit_code((val[0] / 10) % 10);
      eh[1] = digit_code((val[0] / 100) % 10);
      eh[2] = digit_code(val[0] / 1000) & 8'h7F;
      eh[3] = 8'hFF;
      eh[4] = 8'hFF;
      eh[5] = 8'hFF;
    end
    check("count_sat",  count_a,    to_bcd(val[0]));
    check("rco_sat",    16'(rco_a), 16'(mrco[0]));
    check("ovf_sat",    16'(ovf_a), 16'(movf[0]));
    check("count_wrap", count_b,    to_bcd(val[1]));
    check("rco_wrap",   16'(rco_b), 16'(mrco[1]));
    check("ovf_wrap",   16'(ovf_b), 16'(movf[1]));
    check("hex0", 16'(hex0), 16'(eh[0]));
    check("hex1", 16'(hex1), 16'(eh[1]));
    check("hex2", 16'(hex2), 16'(eh[2]));
    check("hex3", 16'(hex3), 16'(eh[3]));
    check("hex4", 16'(hex4), 16'(eh[4]));
    check("hex5", 16'(hex5), 16'(eh[5]));
  endtask

  initial begin
    bit c, e, l;
    logic [15:0] d;
    clear_    = 1'b0;
    en        = 1'b0;
    load      = 1'b0;
    load_data = 16'h0000;
`ifdef GOBUFFS_SCROLL_EN
    msg_mode  = 1'b0;
`endif
    presc = 0; midx = 0; mdiv = 0;
    for (int i = 0; i < 2; i++) begin val[i] = 0; mrco[i] = 0; movf[i] = 0; end

    // Reset
    cyc(0, 0, 0, 16'h0000);
    check("rst_count", count_a, 16'h0000);
    check("rst_rco", 16'(rco_a), 16'h0);
    check("rst_ovf", 16'(ovf_a), 16'h0);
    check("rst_hex0", 16'(hex0), 16'h00C0);
    check("rst_hex2", 16'(hex2), 16'h0040);
    check("rst_hex5", 16'(hex5), 16'h00FF);

    // Counting and hold
    repeat (20) cyc(1, 1, 0, 16'h0000);
    check("cnt_20", count_a, 16'h0010);
    repeat (10) cyc(1, 0, 0, 16'h0000);
    check("hold_10", count_a, 16'h0010);

    // Carry ripple across three digits
    cyc(1, 0, 1, 16'h0999);
    repeat (2) cyc(1, 1, 0, 16'h0000);
    check("carry_cnt", count_a, 16'h1000);
    check("carry_hex2", 16'(hex2), 16'h0079);
    check("carry_hex1", 16'(hex1), 16'h00C0);
    check("carry_hex0", 16'(hex0), 16'h00C0);

    // Overflow: saturate vs wrap
    cyc(1, 0, 1, 16'h9998);
    repeat (3) cyc(1, 1, 0, 16'h0000);
    check("pre_ovf_rco", 16'(rco_a), 16'h0);
    check("pre_ovf_cnt", count_a, 16'h9999);
    cyc(1, 1, 0, 16'h0000);
    check("ovf_rco", 16'(rco_a), 16'h1);
    check("ovf_flag", 16'(ovf_a), 16'h1);
    check("ovf_sat_cnt", count_a, 16'h9999);
    check("ovf_wrap_cnt", count_b, 16'h0000);
    cyc(1, 1, 0, 16'h0000);
    check("rco_one_cycle", 16'(rco_a), 16'h0);
    check("ovf_sticky", 16'(ovf_a), 16'h1);

    // Priority and invalid digits
    cyc(0, 1, 1, 16'h1234);
    check("clr_over_load", count_a, 16'h0000);
    cyc(1, 1, 1, 16'h1F2A);
    check("load_invalid", count_a, 16'h1020);
    check("load_ovf_clr", 16'(ovf_a), 16'h0);

`ifdef GOBUFFS_SCROLL_EN
    msg_mode = 1'b1;
    cyc(1, 1, 0, 16'h0000);
    check("msg_h5", 16'(hex5), 16'h00C2);
    check("msg_h0", 16'(hex0), 16'h008E);
    repeat (2) cyc(1, 1, 0, 16'h0000);
    check("scroll_h5", 16'(hex5), 16'h00C0);
    check("scroll_h1", 16'(hex1), 16'h008E);
    msg_mode = 1'b0;
    cyc(1, 1, 0, 16'h0000);
    check("msg_off_h3", 16'(hex3), 16'h00FF);
`endif

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      c = ($urandom_range(0, 59) != 0);
      l = ($urandom_range(0, 24) == 0);
      e = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) d = to_bcd(9990 + int'($urandom_range(0, 9)));
      else d = 16'($urandom);
`ifdef GOBUFFS_SCROLL_EN
      if ($urandom_range(0, 29) == 0) msg_mode = ~msg_mode;
`endif
      cyc(c, e, l, d);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
